contador_sched: RTL

- Scheduler that shares one contadorA 4-bit counter (ports enable, modo, D, Q, rco) between two requesters.
- Each requester submits a job over a valid/ready handshake. A job is a preset value, a count mode and a run length.
- The block arbitrates round-robin, preloads the counter, runs it for the requested number of cycles, and reports the final count and wrap count.

---
 rtl/contador_sched.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/contador_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : contador_sched                                               |
// | Description : Shares one contadorA counter (enable/modo/D in, Q/rco out)   |
// |               between two requesters. A job (preset d, mode, run length)   |
// |               is accepted over valid/ready, the counter is preloaded with  |
// |               d, run for len cycles in the requested mode, and the final   |
// |               Q plus the number of rco wraps seen are reported.            |
// |                                                                            |
// | Ports       : clk, reset_L (sync, active low)                              |
// |               req0_* / req1_* : valid, modo, d, len in; ready out          |
// |               enable, modo, D : counter control out                        |
// |               Q, rco          : counter state in                           |
// |               done_valid/id/q/rco_cnt : completion report, busy            |
// |                                                                            |
// | Build macro : CTRL_FIXED_PRIO_EN - fixed priority (requester 0 wins);      |
// |               undefined gives round-robin arbitration.                     |
// |                                                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module contador_sched #(
    parameter int CNT_W = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    // requester 0
    input  logic             req0_valid,
    input  logic [1:0]       req0_modo,
    input  logic [CNT_W-1:0] req0_d,
    input  logic [LEN_W-1:0] req0_len,
    output logic             req0_ready,
    // requester 1
    input  logic             req1_valid,
    input  logic [1:0]       req1_modo,
    input  logic [CNT_W-1:0] req1_d,
    input  logic [LEN_W-1:0] req1_len,
    output logic             req1_ready,
    // shared counter
    output logic             enable,
    output logic [1:0]       modo,
    output logic [CNT_W-1:0] D,
    input  logic [CNT_W-1:0] Q,
    input  logic             rco,
    // completion report
    output logic             done_valid,
    output logic             done_id,
    output logic [CNT_W-1:0] done_q,
    output logic [LEN_W-1:0] done_rco_cnt,
    output logic             busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [1:0]       c_MODE_UP   = 2'b00;
    localparam logic [1:0]       c_MODE_LOAD = 2'b11;
    localparam logic [LEN_W-1:0] c_LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] c_LEN_MAX   = {LEN_W{1'b1}};

    logic [1:0]       r_state;
    logic             r_enable;
    logic [1:0]       r_modo;
    logic [CNT_W-1:0] r_d;
    logic             r_id;
    logic [1:0]       r_job_modo;
    logic [LEN_W-1:0] r_remain;
    logic [LEN_W-1:0] r_rco_cnt;
    logic             r_prev_run;
    logic             r_done_id;
    logic [CNT_W-1:0] r_done_q;
    logic [LEN_W-1:0] r_done_rco_cnt;

    logic             w_idle;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_take;
    logic [1:0]       w_sel_modo;
    logic [CNT_W-1:0] w_sel_d;
    logic [LEN_W-1:0] w_sel_len;
    logic             w_rco_inc;
    logic [LEN_W-1:0] w_rco_sum;

    assign w_idle = (r_state == c_IDLE);

    // ready implies valid, so a grant is also the handshake itself.
`ifdef CTRL_FIXED_PRIO_EN
    assign w_grant0 = w_idle && req0_valid;
    assign w_grant1 = w_idle && req1_valid && !req0_valid;
`else
    // r_ptr names the requester that wins a tie; it flips to the other
    // requester each time a job completes.
    logic r_ptr;
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || !r_ptr);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid ||  r_ptr);
`endif

    assign w_take     = w_grant0 | w_grant1;
    assign w_sel_modo = w_grant1 ? req1_modo : req0_modo;
    assign w_sel_d    = w_grant1 ? req1_d    : req0_d;
    assign w_sel_len  = w_grant1 ? req1_len  : req0_len;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // rco seen in a cycle that follows a RUN cycle is the wrap flag of a RUN
    // edge. This excludes the flag left by the LOAD edge and includes the one
    // from the last RUN edge, which only becomes visible during DONE.
    assign w_rco_inc = r_prev_run && rco;
    assign w_rco_sum = (w_rco_inc && (r_rco_cnt != c_LEN_MAX)) ? (r_rco_cnt + c_LEN_ONE)
                                                                : r_rco_cnt;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state        <= c_IDLE;
            r_enable       <= 1'b0;
            r_modo         <= c_MODE_UP;
            r_d            <= '0;
            r_id           <= 1'b0;
            r_job_modo     <= c_MODE_UP;
            r_remain       <= '0;
            r_rco_cnt      <= '0;
            r_prev_run     <= 1'b0;
            r_done_id      <= 1'b0;
            r_done_q       <= '0;
            r_done_rco_cnt <= '0;
`ifndef CTRL_FIXED_PRIO_EN
            r_ptr          <= 1'b0;
`endif
        end else begin
            r_prev_run <= (r_state == c_RUN);
            r_rco_cnt  <= w_rco_sum;

            case (r_state)
                c_IDLE: begin
                    if (w_take) begin
                        r_id       <= w_grant1;
                        r_job_modo <= w_sel_modo;
                        r_remain   <= w_sel_len;
                        r_rco_cnt  <= '0;
                        r_enable   <= 1'b1;
                        r_modo     <= c_MODE_LOAD;
                        r_d        <= w_sel_d;
                        r_state    <= c_LOAD;
                    end
                end

                c_LOAD: begin
                    if (r_remain != '0) begin
                        // enable and D already hold their RUN values
                        r_modo  <= r_job_modo;
                        r_state <= c_RUN;
                    end else begin
                        r_enable <= 1'b0;
                        r_modo   <= c_MODE_UP;
                        r_d      <= '0;
                        r_state  <= c_DONE;
                    end
                end

                c_RUN: begin
                    if (r_remain == c_LEN_ONE) begin
                        r_enable <= 1'b0;
                        r_modo   <= c_MODE_UP;
                        r_d      <= '0;
                        r_state  <= c_DONE;
                    end else begin
                        r_remain <= r_remain - c_LEN_ONE;
                    end
                end

                c_DONE: begin
                    r_done_id      <= r_id;
                    r_done_q       <= Q;
                    r_done_rco_cnt <= w_rco_sum;
`ifndef CTRL_FIXED_PRIO_EN
                    r_ptr          <= ~r_id;
`endif
                    r_state        <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign enable = r_enable;
    assign modo   = r_modo;
    assign D      = r_d;
    assign busy   = !w_idle;

    // Q and the last rco only settle during DONE, so the report is taken
    // live in that cycle and held from the captured copies afterwards.
    assign done_valid   = (r_state == c_DONE);
    assign done_id      = done_valid ? r_id      : r_done_id;
    assign done_q       = done_valid ? Q         : r_done_q;
    assign done_rco_cnt = done_valid ? w_rco_sum : r_done_rco_cnt;

endmodule
`default_nettype wire
